// File: rtl/alu_mw_seq.sv
// Multi-byte ADD/LSL/LSR sequencer driving an 8-bit combinational ALU
// one byte per pass, chaining carry/shift bits through a carry flop.
module alu_mw_seq #(
    parameter int         NBYTES  = 2,
    parameter logic [8:0] OP_IDLE = 9'h1FF,
    parameter logic [8:0] KADD    = 9'h001,
    parameter logic [8:0] KLSL    = 9'h002,
    parameter logic [8:0] KLSR    = 9'h003,
    localparam int        W       = 8 * NBYTES
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         START,
    input  logic [1:0]   CMD,
    input  logic [W-1:0] OPA,
    input  logic [W-1:0] OPB,
    input  logic         CIN,
    output logic         BUSY,
    output logic         DONE,
    output logic         ERR,
    output logic [W-1:0] RESULT,
    output logic         CARRY,
    output logic         ZERO,
    output logic         ALU_SET,
    output logic [7:0]   ALU_SETNUM,
    output logic [7:0]   ALU_INPUT,
    output logic [8:0]   ALU_OP,
    output logic         ALU_SC_IN,
    input  logic [7:0]   ALU_OUT,
    input  logic         ALU_SC_OUT,
    input  logic         ALU_ZERO
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETB,
        S_EXEC,
        S_FIN
    } state_t;

    localparam logic [1:0] C_ADD = 2'b00;
    localparam logic [1:0] C_LSL = 2'b01;
    localparam logic [1:0] C_LSR = 2'b10;
    localparam logic [1:0] LAST  = 2'(NBYTES - 1);

    state_t         state_q;
    state_t         state_d;
    logic [1:0]     cmd_q;
    logic [W-1:0]   opa_q;
    logic [W-1:0]   opb_q;
    logic [W-1:0]   acc_q;
    logic [W-1:0]   acc_nxt;
    logic [1:0]     idx_q;
    logic           cf_q;
    logic           za_q;
    logic           err_q;
    logic           accept;
    logic           last_byte;
    logic [7:0]     opa_byte;
    logic [7:0]     opb_byte;

    assign accept    = (state_q == S_IDLE) && START;
    assign last_byte = (cmd_q == C_LSR) ? (idx_q == 2'd0)
                                        : (idx_q == LAST);

    // Byte lanes selected by IDX; the partial result merges the
    // current ALU byte so the final write can commit all bytes at once.
    always_comb begin
        opa_byte = 8'h00;
        opb_byte = 8'h00;
        acc_nxt  = acc_q;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx_q == 2'(i)) begin
                opa_byte           = opa_q[i*8 +: 8];
                opb_byte           = opb_q[i*8 +: 8];
                acc_nxt[i*8 +: 8]  = ALU_OUT;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    unique case (1'b1)
                        (CMD == C_ADD): state_d = S_SETB;
                        (CMD == C_LSL): state_d = S_EXEC;
                        (CMD == C_LSR): state_d = S_EXEC;
                        default:        state_d = S_FIN;
                    endcase
                end
            end
            S_SETB: state_d = S_EXEC;
            S_EXEC: begin
                if (last_byte) begin
                    state_d = S_FIN;
                end else if (cmd_q == C_ADD) begin
                    state_d = S_SETB;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        BUSY       = (state_q != S_IDLE);
        DONE       = (state_q == S_FIN);
        ERR        = (state_q == S_FIN) && err_q;
        ALU_SET    = 1'b0;
        ALU_SETNUM = 8'h00;
        ALU_INPUT  = 8'h00;
        ALU_OP     = OP_IDLE;
        ALU_SC_IN  = 1'b0;
        unique case (state_q)
            S_SETB: begin
                ALU_SET    = 1'b1;
                ALU_SETNUM = opb_byte;
            end
            S_EXEC: begin
                ALU_INPUT = opa_byte;
                ALU_SC_IN = cf_q;
                unique case (1'b1)
                    (cmd_q == C_ADD): ALU_OP = KADD;
                    (cmd_q == C_LSL): ALU_OP = KLSL;
                    (cmd_q == C_LSR): ALU_OP = KLSR;
                    default:          ALU_OP = OP_IDLE;
                endcase
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cmd_q  <= 2'b00;
            opa_q  <= '0;
            opb_q  <= '0;
            acc_q  <= '0;
            idx_q  <= 2'd0;
            cf_q   <= 1'b0;
            za_q   <= 1'b0;
            err_q  <= 1'b0;
            RESULT <= '0;
            CARRY  <= 1'b0;
            ZERO   <= 1'b0;
        end else if (accept) begin
            cmd_q <= CMD;
            opa_q <= OPA;
            opb_q <= OPB;
            acc_q <= '0;
            cf_q  <= CIN;
            za_q  <= 1'b1;
            err_q <= (CMD == 2'b11);
            idx_q <= (CMD == C_LSR) ? LAST : 2'd0;
        end else if (state_q == S_EXEC) begin
            acc_q <= acc_nxt;
            cf_q  <= ALU_SC_OUT;
            za_q  <= za_q & ALU_ZERO;
            // Outputs only change at completion of a legal request.
            if (last_byte) begin
                RESULT <= acc_nxt;
                CARRY  <= ALU_SC_OUT;
                ZERO   <= za_q & ALU_ZERO;
            end else if (cmd_q == C_LSR) begin
                idx_q <= idx_q - 2'd1;
            end else begin
                idx_q <= idx_q + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_mw_seq.sv
// Directed bench for alu_mw_seq with a behavioural 8-bit ALU model
// holding R0 between SETB and EXEC.
module tb_alu_mw_seq;

    localparam logic [8:0] OPI = 9'h1FF;
    localparam logic [8:0] OPA_ADD = 9'h001;
    localparam logic [8:0] OPA_LSL = 9'h002;
    localparam logic [8:0] OPA_LSR = 9'h003;

    logic        CLK = 0;
    logic        RESET_N = 0;
    logic        START = 0;
    logic [1:0]  CMD = 0;
    logic [15:0] OPA = 0;
    logic [15:0] OPB = 0;
    logic        CIN = 0;
    logic        BUSY, DONE, ERR, CARRY, ZERO;
    logic [15:0] RESULT;
    logic        ALU_SET, ALU_SC_IN, ALU_SC_OUT, ALU_ZERO;
    logic [7:0]  ALU_SETNUM, ALU_INPUT, ALU_OUT;
    logic [8:0]  ALU_OP;

    logic [7:0]  r0 = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 CLK = ~CLK;

    alu_mw_seq #(
        .NBYTES(2), .OP_IDLE(OPI),
        .KADD(OPA_ADD), .KLSL(OPA_LSL), .KLSR(OPA_LSR)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .CMD(CMD),
        .OPA(OPA), .OPB(OPB), .CIN(CIN),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RESULT(RESULT),
        .CARRY(CARRY), .ZERO(ZERO),
        .ALU_SET(ALU_SET), .ALU_SETNUM(ALU_SETNUM),
        .ALU_INPUT(ALU_INPUT), .ALU_OP(ALU_OP), .ALU_SC_IN(ALU_SC_IN),
        .ALU_OUT(ALU_OUT), .ALU_SC_OUT(ALU_SC_OUT), .ALU_ZERO(ALU_ZERO)
    );

    always @(posedge CLK) if (ALU_SET) r0 <= ALU_SETNUM;

    always_comb begin
        logic [8:0] s;
        s = 9'h000;
        ALU_OUT = 8'h00;
        ALU_SC_OUT = 1'b0;
        case (ALU_OP)
            OPA_ADD: begin
                s = {1'b0, ALU_INPUT} + {1'b0, r0} + {8'h00, ALU_SC_IN};
                ALU_OUT = s[7:0];
                ALU_SC_OUT = s[8];
            end
            OPA_LSL: begin
                ALU_OUT = {ALU_INPUT[6:0], ALU_SC_IN};
                ALU_SC_OUT = ALU_INPUT[7];
            end
            OPA_LSR: begin
                ALU_OUT = {ALU_SC_IN, ALU_INPUT[7:1]};
                ALU_SC_OUT = ALU_INPUT[0];
            end
            default: begin
            end
        endcase
        ALU_ZERO = (ALU_OUT == 8'h00);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic [1:0] cmd, input logic [15:0] a,
                         input logic [15:0] b, input logic cin,
                         input bit poke, output int lat,
                         output logic [31:0] setmask,
                         output logic [7:0] first_in,
                         output logic err_seen);
        bit got;
        @(negedge CLK);
        CMD = cmd; OPA = a; OPB = b; CIN = cin; START = 1;
        @(posedge CLK);
        #1;
        START = 0; OPA = ~a; OPB = ~b; CIN = ~cin;
        lat = 0; setmask = 0; first_in = 0; err_seen = 0; got = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            if (poke && k == 2) begin
                START = 1;
                CMD = 2'b11;
            end
            if (ALU_SET) setmask[k] = 1'b1;
            if (ALU_OP != OPI && !got) begin
                first_in = ALU_INPUT;
                got = 1;
            end
            if (DONE) begin
                lat = k;
                err_seen = ERR;
                break;
            end
        end
    endtask

    int          lat;
    logic [31:0] sm;
    logic [7:0]  fi;
    logic        es;
    logic        seen;

    initial begin
        #12;
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_err", ERR, 0);
        chk("rst_result", RESULT, 0);
        chk("rst_flags", {CARRY, ZERO}, 0);
        chk("rst_alu", {ALU_SET, ALU_OP, ALU_SC_IN}, {1'b0, OPI, 1'b0});
        @(negedge CLK);
        RESET_N = 1;

        do_op(2'b00, 16'h00FF, 16'h0001, 0, 0, lat, sm, fi, es);
        chk("add1_lat", lat, 5);
        chk("add1_set", sm, 32'h0000000A);
        chk("add1_res", RESULT, 16'h0100);
        chk("add1_cz", {CARRY, ZERO}, 2'b00);
        chk("add1_busy", BUSY, 1);

        do_op(2'b00, 16'hFFFF, 16'h0001, 0, 0, lat, sm, fi, es);
        chk("add2_res", RESULT, 16'h0000);
        chk("add2_cz", {CARRY, ZERO}, 2'b11);

        do_op(2'b01, 16'h8001, 16'h0000, 0, 0, lat, sm, fi, es);
        chk("lsl_lat", lat, 3);
        chk("lsl_res", RESULT, 16'h0002);
        chk("lsl_cz", {CARRY, ZERO}, 2'b10);
        chk("lsl_first", fi, 8'h01);
        chk("lsl_set", sm, 0);

        do_op(2'b10, 16'h0101, 16'h0000, 1, 0, lat, sm, fi, es);
        chk("lsr_lat", lat, 3);
        chk("lsr_res", RESULT, 16'h8080);
        chk("lsr_c", CARRY, 1);

        do_op(2'b10, 16'h1234, 16'h0000, 0, 0, lat, sm, fi, es);
        chk("lsr2_first", fi, 8'h12);
        chk("lsr2_res", RESULT, 16'h091A);
        chk("lsr2_c", CARRY, 0);

        do_op(2'b00, 16'h1200, 16'h0034, 0, 0, lat, sm, fi, es);
        chk("pre_res", RESULT, 16'h1234);
        do_op(2'b11, 16'hAAAA, 16'h5555, 1, 0, lat, sm, fi, es);
        chk("ill_lat", lat, 1);
        chk("ill_err", es, 1);
        chk("ill_res", RESULT, 16'h1234);
        chk("ill_cz", {CARRY, ZERO}, 2'b00);
        @(negedge CLK);
        chk("ill_err_pulse", {ERR, DONE, BUSY}, 3'b000);

        // Abort in the second EXEC cycle of an ADD
        @(negedge CLK);
        CMD = 2'b00; OPA = 16'h1111; OPB = 16'h2222; CIN = 0; START = 1;
        @(posedge CLK);
        #1 START = 0;
        repeat (4) @(negedge CLK);
        chk("mid_state", {BUSY, ALU_OP}, {1'b1, OPA_ADD});
        #1 RESET_N = 0;
        #1;
        chk("ab_busy", BUSY, 0);
        chk("ab_out", {DONE, ERR, CARRY, ZERO}, 0);
        chk("ab_res", RESULT, 0);
        chk("ab_alu", ALU_OP, OPI);
        @(negedge CLK);
        RESET_N = 1;
        seen = 0;
        repeat (6) begin
            @(negedge CLK);
            if (DONE) seen = 1;
        end
        chk("ab_nodone", seen, 0);

        do_op(2'b00, 16'h0102, 16'h0304, 0, 1, lat, sm, fi, es);
        chk("poke_lat", lat, 5);
        chk("poke_err", es, 0);
        chk("poke_res", RESULT, 16'h0406);
        @(negedge CLK);
        chk("b2b_gap", BUSY, 0);
        @(negedge CLK);
        START = 0;
        chk("b2b_acc", {DONE, ERR}, 2'b11);
        chk("b2b_res", RESULT, 16'h0406);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mw_seq.md
# alu_mw_seq

Multi-byte operation sequencer for the 8-bit combinational ALU. Accepts one ADD, LSL or LSR request on operands of NBYTES bytes. Drives the ALU one byte per pass and chains the carry/shift bit between passes through a registered carry flop. Returns the assembled result with carry and zero flags. Sits between the control unit and the ALU, and owns the ALU's SET, SETNUM, INPUT, OP and SC_IN ports while BUSY.

## Interface
- NBYTES, 2: operand width in bytes, legal range 2..4; W = 8*NBYTES
- OP_IDLE, 9'h1FF: ALU opcode driven when no pass is active; must fall to the ALU's default (no-op, zero out) branch
- CLK  in  1  clock, all state updates on rising edge
- RESET_N  in  1  reset; one clock; reset is asynchronous and active-low
- START  in  1  request strobe, sampled only when BUSY=0
- CMD  in  2  00 ADD, 01 LSL, 10 LSR, 11 illegal
- OPA  in  W  operand A (shift source for LSL/LSR)
- OPB  in  W  operand B (ADD only)
- CIN  in  1  carry-in for ADD, fill bit for LSL/LSR
- BUSY  out  1  high in every non-IDLE state
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  one-cycle pulse coincident with DONE for CMD=11
- RESULT  out  W  registered result, held until next completion
- CARRY  out  1  final carry/shift-out bit, registered
- ZERO  out  1  high when all result bytes are zero, registered
- ALU_SET  out  1  to ALU SET
- ALU_SETNUM  out  8  to ALU SETNUM (B byte)
- ALU_INPUT  out  8  to ALU INPUT (A byte)
- ALU_OP  out  9  to ALU OP (kadd / klsl / klsr from definitions, else OP_IDLE)
- ALU_SC_IN  out  1  to ALU SC_IN (carry flop)
- ALU_OUT  in  8  from ALU OUT
- ALU_SC_OUT  in  1  from ALU SC_OUT
- ALU_ZERO  in  1  from ALU ZERO

## Operation
- States: IDLE, SETB, EXEC, FIN. Byte index register IDX is 2 bits wide. Carry flop CF and zero accumulator ZA are also registered.
- Acceptance happens in IDLE when START=1.
  - Register CMD, OPA, OPB. CF<=CIN, ZA<=1.
  - ADD: IDX<=0, go to SETB.
  - LSL: IDX<=0, go to EXEC.
  - LSR: IDX<=NBYTES-1, go to EXEC.
  - CMD=11: go straight to FIN with the error flag set.
- SETB (ADD only) drives ALU_SET=1 and ALU_SETNUM=OPB byte IDX, which loads the ALU's R0. Next state is EXEC.
- EXEC drives ALU_SET=0, ALU_INPUT=OPA byte IDX, ALU_OP=kadd/klsl/klsr and ALU_SC_IN=CF. At the clock edge:
  - RESULT byte IDX<=ALU_OUT
  - CF<=ALU_SC_OUT
  - ZA<=ZA & ALU_ZERO
- After EXEC:
  - If this was the last byte (ADD/LSL: IDX=NBYTES-1; LSR: IDX=0), go to FIN.
  - Otherwise step IDX (+1 for ADD/LSL, -1 for LSR) and go to SETB for ADD, or EXEC for shifts.
- FIN: DONE=1 and BUSY=1 for one cycle. CARRY=CF and ZERO=ZA are presented. ERR=1 if CMD was 11. Next state is IDLE.
- The ERR path leaves RESULT, CARRY and ZERO unchanged.
- Outside SETB/EXEC: ALU_SET=0, ALU_OP=OP_IDLE, ALU_SETNUM=0, ALU_INPUT=0, ALU_SC_IN=0.

## Timing
- Reset (async assert, sync release):
  - State goes to IDLE.
  - BUSY=0, DONE=0, ERR=0, RESULT=0, CARRY=0, ZERO=0, CF=0, IDX=0.
  - ALU outputs take their idle values.
- Reset asserted mid-operation aborts immediately, with no DONE and no partial RESULT retained.
- Latency is counted in cycles from the accepting edge to the cycle in which DONE is high:
  - ADD: 2*NBYTES+1
  - LSL/LSR: NBYTES+1
  - illegal CMD: 1
- BUSY rises in the cycle after acceptance and falls with the return to IDLE. START during BUSY=1, including the FIN cycle, is ignored and not queued.
- A new START is accepted in the first IDLE cycle after FIN, so back-to-back requests have a 1-cycle gap. Operand changes after acceptance have no effect.
- Flag outputs and RESULT are registered. A byte's ALU result is captured at the end of its EXEC cycle.
- The ALU is combinational, so the SETNUM load in SETB and the use of R0 in EXEC rely on the ALU holding R0 across the SETB→EXEC boundary. ALU_SET is deasserted exactly one cycle after it is asserted.

## Test plan
- ADD, NBYTES=2, OPA=16'h00FF, OPB=16'h0001, CIN=0 → RESULT=16'h0100, CARRY=0, ZERO=0, DONE in cycle 5 after acceptance, ALU_SET pulses in cycles 1 and 3.
- ADD OPA=16'hFFFF, OPB=16'h0001, CIN=0 → RESULT=16'h0000, CARRY=1, ZERO=1.
- LSL OPA=16'h8001, CIN=0 → RESULT=16'h0002, CARRY=1, DONE in cycle 3. LSR OPA=16'h0101, CIN=1 → RESULT=16'h8080, CARRY=1, high byte driven first.
- CMD=11 with prior RESULT=16'h1234 → DONE and ERR pulse together in cycle 1, RESULT still 16'h1234. A second START during BUSY is ignored, and the next START is accepted the cycle after FIN.
- RESET_N low in the 2nd EXEC of an ADD → outputs zero immediately, no DONE. A subsequent ADD 16'h0102+16'h0304 completes with 16'h0406.
